// File: rtl/mem_host_ctrl.sv
// Host-side initiator for the 8x8 memory unit: turns a valid/ready request into
// op/select commands, waits for the matching acknowledge or a timeout, then idles.
module mem_host_ctrl #(
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned TIMEOUT    = 8,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_op,
  output logic              mem_select,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_in,
  input  logic              mem_valid,
  input  logic              mem_rw,
  input  logic [DATA_W-1:0] mem_out
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WRITE,
    S_READ,
    S_GAP
  } state_t;

  state_t            state, state_d;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_d;
  logic [TO_W-1:0]   to_cnt, to_cnt_d;
  logic              op_d, select_d, ready_d, rsp_valid_d, rsp_err_d;
  logic [ADDR_W-1:0] adr_d;
  logic [DATA_W-1:0] in_d, rdata_d;
  logic              gap_done, to_expired;

  assign gap_done   = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
  assign to_expired = (to_cnt == TO_W'(TIMEOUT - 1));

  // State and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_INIT;
      gap_cnt    <= '0;
      to_cnt     <= '0;
      mem_op     <= 1'b0;
      mem_select <= 1'b0;
      mem_adr    <= '0;
      mem_in     <= '0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      state      <= state_d;
      gap_cnt    <= gap_cnt_d;
      to_cnt     <= to_cnt_d;
      mem_op     <= op_d;
      mem_select <= select_d;
      mem_adr    <= adr_d;
      mem_in     <= in_d;
      req_ready  <= ready_d;
      rsp_valid  <= rsp_valid_d;
      rsp_err    <= rsp_err_d;
      rsp_rdata  <= rdata_d;
    end
  end

  // Next state and next register values; command defaults to idle (00).
  always_comb begin
    state_d     = state;
    gap_cnt_d   = gap_cnt;
    to_cnt_d    = to_cnt;
    op_d        = 1'b0;
    select_d    = 1'b0;
    adr_d       = mem_adr;
    in_d        = mem_in;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rdata_d     = rsp_rdata;

    unique case (state)
      S_INIT, S_GAP: begin
        if (gap_done) begin
          state_d   = S_IDLE;
          gap_cnt_d = '0;
          ready_d   = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt + GAP_W'(1);
        end
      end

      S_IDLE: begin
        ready_d = 1'b1;
        if (req_valid && req_ready) begin
          ready_d  = 1'b0;
          adr_d    = req_adr;
          in_d     = req_wdata;
          to_cnt_d = '0;
          select_d = 1'b1;
          op_d     = req_we;
          state_d  = req_we ? S_WRITE : S_READ;
        end
      end

      S_WRITE, S_READ: begin
        op_d     = (state == S_WRITE);
        select_d = 1'b1;
        to_cnt_d = to_cnt + TO_W'(1);
        // An acknowledge in the expiry cycle takes priority over the timeout.
        if (mem_valid && (mem_rw == (state == S_WRITE))) begin
          rsp_valid_d = 1'b1;
          if (state == S_READ) rdata_d = mem_out;
        end else if (to_expired) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
        if (rsp_valid_d) begin
          op_d      = 1'b0;
          select_d  = 1'b0;
          gap_cnt_d = '0;
          state_d   = S_GAP;
        end
      end

      default: state_d = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_mem_host_ctrl.sv
// Directed bench for mem_host_ctrl: reset, write/read, timeouts, back-to-back and mid-write reset.
module tb_mem_host_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_we;
  logic [2:0] req_adr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       mem_op, mem_select;
  logic [2:0] mem_adr;
  logic [7:0] mem_in;
  logic       mem_valid, mem_rw;
  logic [7:0] mem_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_host_ctrl #(.ADDR_W(3), .DATA_W(8), .TIMEOUT(8), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_op(mem_op), .mem_select(mem_select), .mem_adr(mem_adr), .mem_in(mem_in),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_out(mem_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cmd(input string tag, input logic [1:0] exp);
    chk(tag, 32'({mem_op, mem_select}), 32'(exp));
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic e, input logic [7:0] d);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'(v));
    if (v) chk({tag, "_err"}, 32'(rsp_err), 32'(e));
    chk({tag, "_rdata"}, 32'(rsp_rdata), 32'(d));
  endtask

  task automatic issue(input logic we, input logic [2:0] adr, input logic [7:0] wd);
    req_valid = 1'b1;
    req_we    = we;
    req_adr   = adr;
    req_wdata = wd;
  endtask

  // The forbidden 10 command must never reach the memory unit.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      assert ({mem_op, mem_select} !== 2'b10) else begin
        errors++;
        $error("FAIL cmd_10 observed=%b expected=not 10", {mem_op, mem_select});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_wdata = '0;
    mem_valid = 1'b0; mem_rw = 1'b0; mem_out = '0;
    repeat (3) step();
    chk_cmd("rst_cmd", 2'b00);
    chk("rst_adr", 32'(mem_adr), 0);
    chk("rst_in", 32'(mem_in), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk_rsp("rst", 1'b0, 1'b0, 8'h00);
    chk("rst_err", 32'(rsp_err), 0);
    rst_n = 1'b1;

    // INIT: two idle cycles, then ready
    step();
    chk("init1_ready", 32'(req_ready), 0);
    chk_cmd("init1_cmd", 2'b00);
    step();
    chk("init2_ready", 32'(req_ready), 1);
    chk_cmd("init2_cmd", 2'b00);
    chk_rsp("init2", 1'b0, 1'b0, 8'h00);

    // Write 55 to address 0, ack two cycles after acceptance
    issue(1'b1, 3'd0, 8'h55);
    step();
    req_valid = 1'b0;
    chk_cmd("wr_cmd", 2'b11);
    chk("wr_in", 32'(mem_in), 'h55);
    chk("wr_adr", 32'(mem_adr), 0);
    chk("wr_ready", 32'(req_ready), 0);
    step();
    chk_cmd("wr_hold", 2'b11);
    chk("wr_nodone", 32'(rsp_valid), 0);
    mem_valid = 1'b1; mem_rw = 1'b1;
    step();
    mem_valid = 1'b0;
    chk_rsp("wr_ack", 1'b1, 1'b0, 8'h00);
    chk_cmd("wr_gap1", 2'b00);
    step();
    chk_rsp("wr_pulse", 1'b0, 1'b0, 8'h00);
    chk("wr_gap_ready", 32'(req_ready), 0);
    chk_cmd("wr_gap2", 2'b00);
    step();
    chk("wr_idle_ready", 32'(req_ready), 1);

    // Read back address 0
    issue(1'b0, 3'd0, 8'h00);
    step();
    req_valid = 1'b0;
    chk_cmd("rd_cmd", 2'b01);
    mem_valid = 1'b1; mem_rw = 1'b0; mem_out = 8'h55;
    step();
    mem_valid = 1'b0; mem_out = 8'h00;
    chk_rsp("rd_ack", 1'b1, 1'b0, 8'h55);
    step();
    chk_rsp("rd_hold", 1'b0, 1'b0, 8'h55);
    step();
    chk("rd_idle_ready", 32'(req_ready), 1);

    // Timeout: read address 7 with no acknowledge
    issue(1'b0, 3'd7, 8'h00);
    step();
    req_valid = 1'b0;
    chk("to_adr", 32'(mem_adr), 7);
    for (int k = 1; k < 8; k++) begin
      step();
      chk("to_wait", 32'(rsp_valid), 0);
    end
    step();
    chk_rsp("to_done", 1'b1, 1'b1, 8'h55);
    chk_cmd("to_cmd", 2'b00);
    step();
    chk("to_pulse", 32'(rsp_valid), 0);
    step();
    chk("to_idle_ready", 32'(req_ready), 1);

    // Wrong-direction handshake during a read still times out
    issue(1'b0, 3'd2, 8'h00);
    step();
    req_valid = 1'b0;
    mem_valid = 1'b1; mem_rw = 1'b1; mem_out = 8'hEE;
    for (int k = 1; k < 8; k++) begin
      step();
      chk("wd_wait", 32'(rsp_valid), 0);
    end
    step();
    chk_rsp("wd_done", 1'b1, 1'b1, 8'h55);
    mem_valid = 1'b0; mem_out = 8'h00;
    repeat (2) step();
    chk("wd_idle_ready", 32'(req_ready), 1);

    // Acknowledge arriving in the expiry cycle wins
    issue(1'b0, 3'd4, 8'h00);
    step();
    req_valid = 1'b0;
    repeat (7) step();
    chk("ex_wait", 32'(rsp_valid), 0);
    mem_valid = 1'b1; mem_rw = 1'b0; mem_out = 8'h3C;
    step();
    mem_valid = 1'b0; mem_out = 8'h00;
    chk_rsp("ex_ack", 1'b1, 1'b0, 8'h3C);
    repeat (2) step();
    chk("ex_idle_ready", 32'(req_ready), 1);

    // Back-to-back: write A3 @5, then read @5 with req_valid held high
    issue(1'b1, 3'd5, 8'hA3);
    step();
    chk_cmd("bb_wr_cmd", 2'b11);
    issue(1'b0, 3'd5, 8'h00);
    mem_valid = 1'b1; mem_rw = 1'b1;
    step();
    mem_valid = 1'b0;
    chk_rsp("bb_wr_ack", 1'b1, 1'b0, 8'h3C);
    step();
    chk_cmd("bb_gap_cmd", 2'b00);
    chk("bb_gap_ready", 32'(req_ready), 0);
    step();
    chk_cmd("bb_idle_cmd", 2'b00);
    chk("bb_idle_ready", 32'(req_ready), 1);
    step();
    req_valid = 1'b0;
    chk_cmd("bb_rd_cmd", 2'b01);
    chk("bb_rd_adr", 32'(mem_adr), 5);
    mem_valid = 1'b1; mem_rw = 1'b0; mem_out = 8'hA3;
    step();
    mem_valid = 1'b0; mem_out = 8'h00;
    chk_rsp("bb_rd_ack", 1'b1, 1'b0, 8'hA3);
    repeat (2) step();
    chk("bb_end_ready", 32'(req_ready), 1);

    // Reset in the middle of a write
    issue(1'b1, 3'd1, 8'hFF);
    step();
    req_valid = 1'b0;
    chk_cmd("mr_cmd", 2'b11);
    rst_n = 1'b0;
    #1;
    chk_cmd("mr_rst_cmd", 2'b00);
    chk("mr_rst_in", 32'(mem_in), 0);
    chk("mr_rst_adr", 32'(mem_adr), 0);
    chk("mr_rst_ready", 32'(req_ready), 0);
    chk_rsp("mr_rst", 1'b0, 1'b0, 8'h00);
    mem_valid = 1'b1; mem_rw = 1'b1;
    step();
    chk("mr_no_rsp", 32'(rsp_valid), 0);
    mem_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("mr_init_ready", 32'(req_ready), 0);
    chk("mr_init_rsp", 32'(rsp_valid), 0);
    step();
    chk("mr_idle_ready", 32'(req_ready), 1);
    chk("mr_idle_rsp", 32'(rsp_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_host_ctrl.md
Name: mem_host_ctrl

Overview:
- Host-side initiator for the 8x8 memory unit: the block that drives `op`/`select`/`adr`/`in` into the memory unit's FSM and consumes `valid`/`rw`/`out`.
- Converts a simple request/response handshake from upstream logic into the memory unit's command encoding.
- Sequences the idle/stable gaps the memory FSM needs between operations.
- Returns read data, write acknowledge and timeout errors to the requester.

Parameters:
- ADDR_W, 3, memory address width (8 words).
- DATA_W, 8, word width.
- TIMEOUT, 8, max cycles waiting for memory acknowledge before error (>=2).
- GAP_CYCLES, 2, cycles of idle command (op=0, select=0) driven after every transaction (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  upstream request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_we  in  1  1=write, 0=read.
- req_adr  in  ADDR_W  target word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse: transaction finished.
- rsp_rdata  out  DATA_W  read data; held until the next rsp_valid.
- rsp_err  out  1  qualified by rsp_valid: 1 = timeout.
- mem_op  out  1  to memory unit `op`.
- mem_select  out  1  to memory unit `select`.
- mem_adr  out  ADDR_W  to memory unit `adr`.
- mem_in  out  DATA_W  to memory unit `in`.
- mem_valid  in  1  from memory unit `valid`.
- mem_rw  in  1  from memory unit `rw` (1 = write cycle, 0 = read cycle).
- mem_out  in  DATA_W  from memory unit `out`.

Behaviour:
- Command encoding on {mem_op, mem_select}:
  - 00 idle/stable.
  - 11 write.
  - 01 read.
  - 10 never driven.
- Reset (async assert, sync release):
  - state=INIT; mem_op=0, mem_select=0, mem_adr=0, mem_in=0.
  - req_ready=0; rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - Timeout and gap counters = 0.
- INIT:
  - Drive 00 for GAP_CYCLES cycles so the memory FSM settles into idle, then go to IDLE.
- IDLE:
  - req_ready=1; drive 00.
  - On req_valid & req_ready, register req_we/req_adr/req_wdata into mem_adr/mem_in and go to WRITE or READ.
  - Requests while req_ready=0 are ignored; upstream holds them until accepted.
- WRITE:
  - Drive 11, mem_adr and mem_in held stable.
  - Acknowledge is the first cycle with mem_valid=1 & mem_rw=1: pulse rsp_valid with rsp_err=0; rsp_rdata unchanged; go to GAP.
- READ:
  - Drive 01.
  - Acknowledge is the first cycle with mem_valid=1 & mem_rw=0: capture mem_out into rsp_rdata on that edge, pulse rsp_valid with rsp_err=0, go to GAP.
- Timeout:
  - Counter clears on entry to WRITE/READ and increments every cycle in them.
  - If it reaches TIMEOUT without acknowledge: rsp_valid=1, rsp_err=1, rsp_rdata unchanged, go to GAP.
  - An acknowledge in the same cycle as expiry wins (success, no error).
- Wrong-direction handshake: mem_valid with mismatched mem_rw is not an acknowledge; the timeout keeps counting.
- GAP:
  - Drive 00 for GAP_CYCLES cycles, then IDLE.
  - req_ready stays 0 throughout.
- Latency:
  - Request accepted at edge N; command visible from N.
  - rsp_valid is asserted the cycle after the acknowledge sample.
  - Next acceptance no earlier than GAP_CYCLES+1 cycles after rsp_valid.
- rsp_valid never lasts more than one cycle; at most one outstanding transaction.
- Reset mid-transaction: outputs return to reset values immediately; no rsp_valid for the aborted transaction.
- Addresses 0..7 are all legal; there is no wrap behaviour beyond the 3-bit field.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release → mem_op/mem_select=00 for 2 cycles, then req_ready=1; all rsp outputs 0.
- Write: req_we=1, adr=3'b000, wdata=8'h55, memory acks valid=1/rw=1 after 2 cycles → mem_in=8'h55 and {op,select}=11 held until ack, one rsp_valid with rsp_err=0, then 2 cycles of 00, req_ready=1.
- Read-back: read adr=000, memory returns out=8'h55 with valid=1/rw=0 → {op,select}=01, rsp_valid pulse, rsp_rdata=8'h55 and held after the pulse.
- Timeout: read adr=3'b111, mem_valid held 0 → rsp_valid with rsp_err=1 exactly TIMEOUT cycles after acceptance, rsp_rdata unchanged; also mem_valid=1 with rw=1 during a read → still times out.
- Back-to-back: req_valid held high with write 8'hA3 @5 then read @5 → second request accepted only after the gap; read returns 8'hA3; `10` never appears on {op,select}.
- Reset mid-write: assert rst_n while in WRITE → outputs return to reset values asynchronously in the same cycle; no rsp_valid pulse.
